// File: rtl/pc_sequencer.sv
// pc_sequencer
// -------------
// Instruction-fetch front end. It keeps the next fetch address in fetchPc_q,
// issues one instruction-memory request at a time, and presents each returned
// word to decode through a valid/ready handshake. It also handles redirects
// (trap, return-from-trap, taken branch), halting, and flushing an in-flight
// request whose data is no longer wanted.
//
// Parameters
//   RESET_PC      first fetch address after reset
//   TRAP_VEC      redirect target for a trap
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   trap_i        trap request (highest-priority redirect)
//   trap_ret_i    return-from-trap, target epc_i
//   epc_i         return-from-trap target
//   br_valid_i    taken branch/jump, target br_pc_i
//   br_pc_i       branch target
//   stall_i       core stall; blocks hand-off to decode
//   halt_i        halt request, honoured in IDLE or on a decode hand-off
//   imem_req_o    instruction-memory request (high in REQ and DRAIN)
//   imem_addr_o   registered request address, stable while imem_req_o=1
//   imem_ack_i    memory acknowledge, imem_rdata_i is valid with it
//   imem_rdata_i  returned instruction word
//   if_valid_o    decode-side valid (high in VALID)
//   if_ready_i    decode-side ready
//   if_pc_o       address of the instruction being presented
//   if_instr_o    instruction being presented
//   halted_o      sequencer is halted
//   misalign_o    one-cycle pulse when a misaligned branch target is taken
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_i,
    input  logic        trap_ret_i,
    input  logic [31:0] epc_i,
    input  logic        br_valid_i,
    input  logic [31:0] br_pc_i,
    input  logic        stall_i,
    input  logic        halt_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        halted_o,
    output logic        misalign_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        VALID,
        DRAIN,
        HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetchPc_q, fetchPc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ifPc_q, ifPc_d;
    logic [31:0] ifInstr_q, ifInstr_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic [31:0] target;
    logic        fire;

    // Redirect source and target; trap beats return-from-trap beats branch.
    always_comb begin
        redirect = trap_i | trap_ret_i | br_valid_i;
        target   = br_pc_i;
        if (trap_i) begin
            target = TRAP_VEC;
        end else if (trap_ret_i) begin
            target = epc_i;
        end
    end

    assign fire = (state_q == VALID) & if_ready_i & ~stall_i;

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetchPc_q  <= RESET_PC;
            addr_q     <= 32'h0;
            ifPc_q     <= 32'h0;
            ifInstr_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            addr_q     <= addr_d;
            ifPc_q     <= ifPc_d;
            ifInstr_q  <= ifInstr_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic. A redirect always replaces fetchPc; whether it can be
    // acted on immediately depends on whether a memory request is outstanding.
    always_comb begin
        state_d    = state_q;
        fetchPc_d  = fetchPc_q;
        addr_d     = addr_q;
        ifPc_d     = ifPc_q;
        ifInstr_d  = ifInstr_q;
        misalign_d = 1'b0;

        if (redirect) begin
            misalign_d = ~trap_i & ~trap_ret_i & (br_pc_i[1:0] != 2'b00);
        end

        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetchPc_d = {target[31:2], 2'b00};
                    state_d   = REQ;
                end else if (halt_i) begin
                    state_d = HALTED;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    // With a same-cycle ack the stale word is dropped and the
                    // new target is requested straight away; otherwise the
                    // outstanding request has to be drained first.
                    fetchPc_d = {target[31:2], 2'b00};
                    state_d   = imem_ack_i ? REQ : DRAIN;
                end else if (imem_ack_i) begin
                    ifInstr_d = imem_rdata_i;
                    ifPc_d    = addr_q;
                    fetchPc_d = addr_q + 32'd4;
                    state_d   = VALID;
                end
            end
            VALID: begin
                if (redirect) begin
                    fetchPc_d = {target[31:2], 2'b00};
                    state_d   = REQ;
                end else if (fire) begin
                    state_d = halt_i ? HALTED : REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetchPc_d = {target[31:2], 2'b00};
                end
                if (imem_ack_i) begin
                    state_d = REQ;
                end
            end
            HALTED: begin
                if (redirect) begin
                    fetchPc_d = {target[31:2], 2'b00};
                    state_d   = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The request address is latched only when a new request starts, so it
        // stays put for the whole time imem_req_o is high.
        if ((state_d == REQ) && ((state_q != REQ) || imem_ack_i)) begin
            addr_d = fetchPc_d;
        end
    end

    assign imem_req_o  = (state_q == REQ) | (state_q == DRAIN);
    assign imem_addr_o = addr_q;
    assign if_valid_o  = (state_q == VALID);
    assign if_pc_o     = ifPc_q;
    assign if_instr_o  = ifInstr_q;
    assign halted_o    = (state_q == HALTED);
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// ---------------
// Directed bench for pc_sequencer: a linear sequence of steps with expected
// values worked out by hand. Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        trap_i;
    logic        trap_ret_i;
    logic [31:0] epc_i;
    logic        br_valid_i;
    logic [31:0] br_pc_i;
    logic        stall_i;
    logic        halt_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        halted_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .trap_i       (trap_i),
        .trap_ret_i   (trap_ret_i),
        .epc_i        (epc_i),
        .br_valid_i   (br_valid_i),
        .br_pc_i      (br_pc_i),
        .stall_i      (stall_i),
        .halt_i       (halt_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_ready_i   (if_ready_i),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o),
        .halted_o     (halted_o),
        .misalign_o   (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed pattern of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Sequencer is in REQ for expAddr: check the request, ack it next cycle
    // and check the word presented to decode.
    task automatic fetchWord(input logic [31:0] expAddr);
        checkOutput("fetch_req", 32'(imem_req_o), 32'd1);
        checkOutput("fetch_addr", imem_addr_o, expAddr);
        imem_ack_i   = 1'b1;
        imem_rdata_i = memWord(expAddr);
        applyStimulus(1);
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        checkOutput("fetch_valid", 32'(if_valid_o), 32'd1);
        checkOutput("fetch_pc", if_pc_o, expAddr);
        checkOutput("fetch_instr", if_instr_o, memWord(expAddr));
    endtask

    initial begin
        rst          = 1'b1;
        trap_i       = 1'b0;
        trap_ret_i   = 1'b0;
        epc_i        = 32'h0;
        br_valid_i   = 1'b0;
        br_pc_i      = 32'h0;
        stall_i      = 1'b0;
        halt_i       = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        if_ready_i   = 1'b1;

        // Reset state.
        applyStimulus(2);
        checkOutput("rst_req", 32'(imem_req_o), 32'd0);
        checkOutput("rst_addr", imem_addr_o, 32'h0);
        checkOutput("rst_valid", 32'(if_valid_o), 32'd0);
        checkOutput("rst_pc", if_pc_o, 32'h0);
        checkOutput("rst_instr", if_instr_o, 32'h0);
        checkOutput("rst_halted", 32'(halted_o), 32'd0);
        checkOutput("rst_misalign", 32'(misalign_o), 32'd0);

        // Sequential fetch 0, 4, 8, then on to 0x10.
        rst = 1'b0;
        applyStimulus(1);
        for (int a = 0; a <= 32'h10; a += 4) begin
            fetchWord(32'(a));
            if (a != 32'h10) applyStimulus(1);
        end

        // Stall while presenting 0x10: everything holds, no new request.
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("stall_valid", 32'(if_valid_o), 32'd1);
            checkOutput("stall_pc", if_pc_o, 32'h10);
            checkOutput("stall_instr", if_instr_o, memWord(32'h10));
            checkOutput("stall_req", 32'(imem_req_o), 32'd0);
        end
        stall_i = 1'b0;
        applyStimulus(1);
        checkOutput("unstall_addr", imem_addr_o, 32'h14);

        // Walk up to a request at 0x20.
        for (int a = 32'h14; a < 32'h20; a += 4) begin
            fetchWord(32'(a));
            applyStimulus(1);
        end
        checkOutput("pre_br_addr", imem_addr_o, 32'h20);

        // Misaligned branch while 0x20 is outstanding: drain, then 0x200.
        br_valid_i = 1'b1;
        br_pc_i    = 32'h203;
        applyStimulus(1);
        br_valid_i = 1'b0;
        checkOutput("drain_req", 32'(imem_req_o), 32'd1);
        checkOutput("drain_addr", imem_addr_o, 32'h20);
        checkOutput("drain_misalign", 32'(misalign_o), 32'd1);
        checkOutput("drain_valid", 32'(if_valid_o), 32'd0);
        applyStimulus(1);
        checkOutput("drain_misalign_off", 32'(misalign_o), 32'd0);
        checkOutput("drain_hold_addr", imem_addr_o, 32'h20);
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        applyStimulus(1);
        imem_ack_i   = 1'b0;
        checkOutput("br_addr", imem_addr_o, 32'h200);
        checkOutput("br_req", 32'(imem_req_o), 32'd1);
        checkOutput("br_valid_off", 32'(if_valid_o), 32'd0);
        checkOutput("br_discard", if_instr_o, memWord(32'h1C));
        checkOutput("br_misalign_once", 32'(misalign_o), 32'd0);

        // All three redirects together: trap vector wins, no misalign pulse.
        trap_i     = 1'b1;
        trap_ret_i = 1'b1;
        epc_i      = 32'h400;
        br_valid_i = 1'b1;
        br_pc_i    = 32'h301;
        applyStimulus(1);
        trap_i     = 1'b0;
        trap_ret_i = 1'b0;
        br_valid_i = 1'b0;
        checkOutput("prio_misalign", 32'(misalign_o), 32'd0);
        imem_ack_i = 1'b1;
        applyStimulus(1);
        imem_ack_i = 1'b0;
        checkOutput("prio_addr", imem_addr_o, 32'h100);

        // Halt on hand-off, stay halted, leave via return-from-trap.
        fetchWord(32'h100);
        halt_i = 1'b1;
        applyStimulus(1);
        halt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("halt_halted", 32'(halted_o), 32'd1);
            checkOutput("halt_req", 32'(imem_req_o), 32'd0);
            applyStimulus(1);
        end
        trap_ret_i = 1'b1;
        epc_i      = 32'h44;
        applyStimulus(1);
        trap_ret_i = 1'b0;
        checkOutput("ret_halted", 32'(halted_o), 32'd0);
        checkOutput("ret_req", 32'(imem_req_o), 32'd1);
        checkOutput("ret_addr", imem_addr_o, 32'h44);

        // Branch to the top of memory and wrap around to 0.
        br_valid_i = 1'b1;
        br_pc_i    = 32'hFFFF_FFFC;
        applyStimulus(1);
        br_valid_i = 1'b0;
        imem_ack_i = 1'b1;
        applyStimulus(1);
        imem_ack_i = 1'b0;
        fetchWord(32'hFFFF_FFFC);
        applyStimulus(1);
        checkOutput("wrap_addr", imem_addr_o, 32'h0);

        // Halt is ignored while a request is outstanding.
        halt_i = 1'b1;
        applyStimulus(1);
        halt_i = 1'b0;
        checkOutput("halt_in_req_req", 32'(imem_req_o), 32'd1);
        checkOutput("halt_in_req_halted", 32'(halted_o), 32'd0);

        // Reset during an outstanding request, then a late ack is ignored.
        rst        = 1'b1;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'h1234_5678;
        applyStimulus(1);
        checkOutput("rst2_req", 32'(imem_req_o), 32'd0);
        checkOutput("rst2_addr", imem_addr_o, 32'h0);
        checkOutput("rst2_valid", 32'(if_valid_o), 32'd0);
        checkOutput("rst2_pc", if_pc_o, 32'h0);
        rst = 1'b0;
        applyStimulus(1);
        imem_ack_i = 1'b0;
        checkOutput("late_ack_valid", 32'(if_valid_o), 32'd0);
        checkOutput("late_ack_instr", if_instr_o, 32'h0);
        checkOutput("late_ack_req", 32'(imem_req_o), 32'd1);
        checkOutput("late_ack_addr", imem_addr_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, SHALL set the trap redirect target.
REQ-003 clk  in  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 trap_i  in  1  trap request; trap_ret_i  in  1  return-from-trap; epc_i  in  32  return target.
REQ-006 br_valid_i  in  1  branch/jump taken; br_pc_i  in  32  branch target.
REQ-007 stall_i  in  1  core stall; halt_i  in  1  halt request.
REQ-008 imem_req_o  out  1; imem_addr_o  out  32; imem_ack_i  in  1; imem_rdata_i  in  32: the instruction-memory handshake.
REQ-009 if_valid_o  out  1; if_ready_i  in  1; if_pc_o  out  32; if_instr_o  out  32: the decode handshake.
REQ-010 halted_o  out  1  halted status; misalign_o  out  1  one-cycle pulse for a misaligned branch target.

Function
REQ-011 The FSM SHALL have five states: IDLE, REQ, VALID, DRAIN and HALTED.
REQ-012 Register fetch_pc SHALL hold the next fetch address; imem_addr_o SHALL be registered, loaded from fetch_pc on entry to REQ, and held stable while imem_req_o=1.
REQ-013 imem_req_o SHALL be 1 exactly in REQ and DRAIN.
REQ-014 IDLE SHALL move to REQ on the next cycle unless halt_i=1, in which case it SHALL move to HALTED.
REQ-015 In REQ, on imem_ack_i=1 with no redirect: if_instr_o<=imem_rdata_i, if_pc_o<=imem_addr_o, fetch_pc<=imem_addr_o+4, and the FSM SHALL move to VALID.
REQ-016 if_valid_o SHALL be 1 exactly in VALID.
REQ-017 fire = if_valid_o & if_ready_i & ~stall_i; in VALID, fire SHALL move to REQ, or to HALTED if halt_i=1; without fire, VALID and all if_* outputs SHALL hold.
REQ-018 redirect = trap_i | trap_ret_i | br_valid_i; target priority SHALL be trap_i (TRAP_VEC), then trap_ret_i (epc_i), then br_valid_i (br_pc_i).
REQ-019 On redirect, fetch_pc SHALL load {target[31:2],2'b00}.
REQ-020 misalign_o SHALL pulse for one cycle when a branch redirect is selected and br_pc_i[1:0]!=0.
REQ-021 Redirect in IDLE or VALID SHALL drop if_valid_o on the next cycle and move to REQ; the held instruction SHALL be discarded.
REQ-022 Redirect in REQ with imem_ack_i=1 in the same cycle SHALL discard rdata and move to REQ with the new target.
REQ-023 Redirect in REQ without ack SHALL move to DRAIN.
REQ-024 DRAIN SHALL keep the old address and imem_req_o=1 until ack; the ack data SHALL be discarded; the FSM SHALL then move to REQ.
REQ-025 A further redirect in DRAIN SHALL overwrite fetch_pc and SHALL NOT leave DRAIN early.
REQ-026 HALTED SHALL drive halted_o=1 and no requests, and SHALL exit to REQ only on redirect.
REQ-027 halt_i in REQ or DRAIN SHALL be ignored until VALID or IDLE is reached.
REQ-028 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000.
REQ-029 rdata SHALL be captured only in REQ with ack; an ack outside REQ or DRAIN SHALL be ignored.

Reset
REQ-030 rst=1 SHALL force state IDLE, fetch_pc=RESET_PC, imem_addr_o=0, imem_req_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=0, halted_o=0, misalign_o=0.
REQ-031 rst SHALL override every input in the same cycle, including during an outstanding request; a late ack after reset SHALL be ignored.

Verification
REQ-032 Reset, then ack each request after 1 cycle with if_ready_i=1 -> imem_addr_o sequence 0,4,8; if_pc_o matches each address; if_instr_o equals the rdata returned for it.
REQ-033 VALID with if_pc_o=0x10 and stall_i=1 for 3 cycles -> if_* stable, no new request; then stall_i=0 -> next request is to 0x14.
REQ-034 br_valid_i=1 with br_pc_i=0x203 while REQ to 0x20 awaits ack -> DRAIN; ack at 0x20 discarded; next request is to 0x200; misalign_o pulses once.
REQ-035 trap_i, trap_ret_i and br_valid_i asserted in the same cycle -> next fetch is TRAP_VEC 0x100.
REQ-036 halt_i with fire in VALID -> halted_o=1 and imem_req_o=0 for 5 cycles; trap_ret_i with epc_i=0x44 -> request to 0x44.
REQ-037 fetch_pc=0xFFFF_FFFC fetched and accepted -> next request is to 0x0000_0000.
